// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the itlb (port 0) and the
// dtlb (port 1). Arbitration is round-robin, and only one walk is in flight at
// a time. The returned PTE is routed back to the requester that owns the walk.
//
// Optional build macro PTW_ARB_MERGE_EN: while a walk is outstanding, a
// request from the non-owner that targets the same 4 KiB page is accepted.
// That request then receives the same PTE, so the walker is not used twice.
module ptw_arbiter #(
    parameter int VA_WIDTH  = 32,
    parameter int PTE_WIDTH = 32,
    parameter int INIT_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 itlb_req_valid_i,
    output logic                 itlb_req_ready_o,
    input  logic [VA_WIDTH-1:0]  itlb_vaddr_i,
    output logic                 itlb_resp_valid_o,
    input  logic                 itlb_resp_ready_i,
    output logic [PTE_WIDTH-1:0] itlb_pte_o,

    input  logic                 dtlb_req_valid_i,
    output logic                 dtlb_req_ready_o,
    input  logic [VA_WIDTH-1:0]  dtlb_vaddr_i,
    output logic                 dtlb_resp_valid_o,
    input  logic                 dtlb_resp_ready_i,
    output logic [PTE_WIDTH-1:0] dtlb_pte_o,

    output logic                 ptw_req_valid_o,
    input  logic                 ptw_req_ready_i,
    output logic [VA_WIDTH-1:0]  ptw_vaddr_o,
    input  logic                 ptw_resp_valid_i,
    output logic                 ptw_resp_ready_o,
    input  logic [PTE_WIDTH-1:0] ptw_pte_i,

    output logic                 busy_o,
    output logic                 owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic                   rr_ptr;
    logic                   owner;
    logic [VA_WIDTH-1:0]    vaddr_q;
    logic [PTE_WIDTH-1:0]   pte_q;
    // Requesters still waiting for their PTE in RESP: bit 0 is itlb, bit 1 is dtlb.
    logic [1:0]             pend_q;
    logic [1:0]             pend_nxt;

    logic                   any_valid;
    logic                   grant_sel;
    logic                   accept;
    logic                   resp_done;
    logic                   merge_hit;
    logic                   merge_pend;

    // Pick the grantee for IDLE. A lone requester wins; on a tie, rr_ptr decides.
    always_comb begin
        any_valid = itlb_req_valid_i | dtlb_req_valid_i;
        grant_sel = (itlb_req_valid_i & dtlb_req_valid_i) ? rr_ptr : dtlb_req_valid_i;
    end

`ifdef PTW_ARB_MERGE_EN
    logic                   merge_q;
    logic                   other_valid;
    logic [VA_WIDTH-1:0]    other_vaddr;

    // Detect a same-page request from the non-owner while the walk is outstanding.
    always_comb begin
        other_valid = owner ? itlb_req_valid_i : dtlb_req_valid_i;
        other_vaddr = owner ? itlb_vaddr_i : dtlb_vaddr_i;
        merge_hit   = ((state == REQ) || (state == WAIT)) && !merge_q && other_valid &&
                      (other_vaddr[VA_WIDTH-1:12] == vaddr_q[VA_WIDTH-1:12]);
        merge_pend  = merge_q;
    end

    // Allow at most one merge per walk. The flag clears when the arbiter is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            merge_q <= 1'b0;
        end else if (state == IDLE) begin
            merge_q <= 1'b0;
        end else if (merge_hit) begin
            merge_q <= 1'b1;
        end
    end
`else
    // Merging is compiled out, so the non-owner waits for the return to IDLE.
    always_comb begin
        merge_hit  = 1'b0;
        merge_pend = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Compute the next state and drive each handshake output only in the state that owns it.
    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        resp_done         = 1'b0;
        pend_nxt          = pend_q;
        itlb_req_ready_o  = 1'b0;
        dtlb_req_ready_o  = 1'b0;
        itlb_resp_valid_o = 1'b0;
        dtlb_resp_valid_o = 1'b0;
        ptw_req_valid_o   = 1'b0;
        ptw_resp_ready_o  = 1'b0;
        case (state)
            IDLE: begin
                itlb_req_ready_o = any_valid & ~grant_sel;
                dtlb_req_ready_o = any_valid & grant_sel;
                if (any_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                ptw_req_valid_o = 1'b1;
                if (ptw_req_ready_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                ptw_resp_ready_o = 1'b1;
                if (ptw_resp_valid_i) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                itlb_resp_valid_o = pend_q[0];
                dtlb_resp_valid_o = pend_q[1];
                pend_nxt = pend_q & ~{dtlb_resp_ready_i, itlb_resp_ready_i};
                if (pend_nxt == 2'b00) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (merge_hit) begin
            if (owner) begin
                itlb_req_ready_o = 1'b1;
            end else begin
                dtlb_req_ready_o = 1'b1;
            end
        end
    end

    // Datapath: latch the grant, latch the PTE, track pending responses and advance round-robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= 1'(INIT_PRIO);
            owner   <= 1'(INIT_PRIO);
            vaddr_q <= '0;
            pte_q   <= '0;
            pend_q  <= 2'b00;
        end else begin
            if (accept) begin
                vaddr_q <= grant_sel ? dtlb_vaddr_i : itlb_vaddr_i;
                owner   <= grant_sel;
            end
            if ((state == WAIT) && ptw_resp_valid_i) begin
                pte_q  <= ptw_pte_i;
                pend_q <= owner ? {1'b1, merge_pend | merge_hit}
                                : {merge_pend | merge_hit, 1'b1};
            end else if (state == RESP) begin
                pend_q <= pend_nxt;
            end
            if (resp_done) begin
                rr_ptr <= ~owner;
            end
        end
    end

    // Data outputs come straight from registers, so no requester input reaches the PTW combinationally.
    always_comb begin
        ptw_vaddr_o = vaddr_q;
        itlb_pte_o  = pte_q;
        dtlb_pte_o  = pte_q;
        busy_o      = (state != IDLE);
        owner_o     = owner;
    end

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: directed bench for ptw_arbiter. The bench itself plays the
// PTW and both TLBs, and all expected values are worked out by hand.
module tb_ptw_arbiter;

    logic        clk;
    logic        rst;
    logic        itlb_req_valid_i;
    logic        itlb_req_ready_o;
    logic [31:0] itlb_vaddr_i;
    logic        itlb_resp_valid_o;
    logic        itlb_resp_ready_i;
    logic [31:0] itlb_pte_o;
    logic        dtlb_req_valid_i;
    logic        dtlb_req_ready_o;
    logic [31:0] dtlb_vaddr_i;
    logic        dtlb_resp_valid_o;
    logic        dtlb_resp_ready_i;
    logic [31:0] dtlb_pte_o;
    logic        ptw_req_valid_o;
    logic        ptw_req_ready_i;
    logic [31:0] ptw_vaddr_o;
    logic        ptw_resp_valid_i;
    logic        ptw_resp_ready_o;
    logic [31:0] ptw_pte_i;
    logic        busy_o;
    logic        owner_o;

    int tests_run;
    int tests_failed;

    ptw_arbiter #(.VA_WIDTH(32), .PTE_WIDTH(32), .INIT_PRIO(0)) dut (
        .clk               (clk),
        .rst               (rst),
        .itlb_req_valid_i  (itlb_req_valid_i),
        .itlb_req_ready_o  (itlb_req_ready_o),
        .itlb_vaddr_i      (itlb_vaddr_i),
        .itlb_resp_valid_o (itlb_resp_valid_o),
        .itlb_resp_ready_i (itlb_resp_ready_i),
        .itlb_pte_o        (itlb_pte_o),
        .dtlb_req_valid_i  (dtlb_req_valid_i),
        .dtlb_req_ready_o  (dtlb_req_ready_o),
        .dtlb_vaddr_i      (dtlb_vaddr_i),
        .dtlb_resp_valid_o (dtlb_resp_valid_o),
        .dtlb_resp_ready_i (dtlb_resp_ready_i),
        .dtlb_pte_o        (dtlb_pte_o),
        .ptw_req_valid_o   (ptw_req_valid_o),
        .ptw_req_ready_i   (ptw_req_ready_i),
        .ptw_vaddr_o       (ptw_vaddr_o),
        .ptw_resp_valid_i  (ptw_resp_valid_i),
        .ptw_resp_ready_o  (ptw_resp_ready_o),
        .ptw_pte_i         (ptw_pte_i),
        .busy_o            (busy_o),
        .owner_o           (owner_o)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move on to the next falling edge, where the bench drives new inputs.
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Run one walk from the cycle after the accept edge. The PTW answers lat cycles after it takes the request.
    task automatic serveWalk(input logic exp_owner, input logic [31:0] exp_vaddr,
                             input logic [31:0] pte, input int lat);
        #1;
        checkOutput("req_valid", ptw_req_valid_o, 1'b1);
        checkOutput("req_vaddr", ptw_vaddr_o, exp_vaddr);
        checkOutput("req_owner", owner_o, exp_owner);
        checkOutput("req_busy", busy_o, 1'b1);
        checkOutput("req_no_regrant", {itlb_req_ready_o, dtlb_req_ready_o}, 2'b00);
        ptw_req_ready_i = 1'b1;
        applyStimulus(1);
        ptw_req_ready_i = 1'b0;
        #1;
        checkOutput("wait_resp_ready", ptw_resp_ready_o, 1'b1);
        checkOutput("wait_req_valid", ptw_req_valid_o, 1'b0);
        checkOutput("wait_resp_valids", {itlb_resp_valid_o, dtlb_resp_valid_o}, 2'b00);
        if (lat > 1) applyStimulus(lat - 1);
        ptw_resp_valid_i = 1'b1;
        ptw_pte_i        = pte;
        applyStimulus(1);
        ptw_resp_valid_i = 1'b0;
        ptw_pte_i        = 32'hDEAD_BEEF;
        #1;
        checkOutput("resp_itlb_valid", itlb_resp_valid_o, !exp_owner);
        checkOutput("resp_dtlb_valid", dtlb_resp_valid_o, exp_owner);
        checkOutput("resp_pte", exp_owner ? dtlb_pte_o : itlb_pte_o, pte);
        checkOutput("resp_ptw_ready", ptw_resp_ready_o, 1'b0);
        if (exp_owner) dtlb_resp_ready_i = 1'b1;
        else           itlb_resp_ready_i = 1'b1;
        applyStimulus(1);
        itlb_resp_ready_i = 1'b0;
        dtlb_resp_ready_i = 1'b0;
        #1;
        checkOutput("idle_busy", busy_o, 1'b0);
        checkOutput("idle_resp_valids", {itlb_resp_valid_o, dtlb_resp_valid_o}, 2'b00);
    endtask

    // Directed sequence covering every scenario in order.
    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        itlb_req_valid_i  = 1'b0;
        itlb_vaddr_i      = '0;
        itlb_resp_ready_i = 1'b0;
        dtlb_req_valid_i  = 1'b0;
        dtlb_vaddr_i      = '0;
        dtlb_resp_ready_i = 1'b0;
        ptw_req_ready_i   = 1'b0;
        ptw_resp_valid_i  = 1'b0;
        ptw_pte_i         = '0;

        // Reset state, then itlb sees ready in the same cycle it raises valid.
        applyStimulus(2);
        rst = 1'b0;
        #1;
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_owner", owner_o, 1'b0);
        checkOutput("rst_handshakes", {itlb_req_ready_o, dtlb_req_ready_o, itlb_resp_valid_o,
                    dtlb_resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o}, 6'b0);
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_1000;
        #1;
        checkOutput("first_itlb_ready", itlb_req_ready_o, 1'b1);
        checkOutput("first_dtlb_ready", dtlb_req_ready_o, 1'b0);
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        serveWalk(1'b0, 32'h0000_1000, 32'h0A00_0001, 1);

        // A single itlb walk whose PTE returns three cycles after accept.
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_2000;
        #1;
        checkOutput("single_ready", itlb_req_ready_o, 1'b1);
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        serveWalk(1'b0, 32'h0000_2000, 32'h1200_0007, 2);

        // Simultaneous requests straight after reset: itlb is served first, then dtlb.
        applyStimulus(1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_0000;
        dtlb_req_valid_i = 1'b1;
        dtlb_vaddr_i     = 32'h0000_1000;
        #1;
        checkOutput("both_itlb_ready", itlb_req_ready_o, 1'b1);
        checkOutput("both_dtlb_ready", dtlb_req_ready_o, 1'b0);
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        serveWalk(1'b0, 32'h0000_0000, 32'h1000_000F, 1);
        checkOutput("held_dtlb_ready", dtlb_req_ready_o, 1'b1);
        applyStimulus(1);
        dtlb_req_valid_i = 1'b0;
        serveWalk(1'b1, 32'h0000_1000, 32'h1100_000F, 1);

        // Fairness: with both requesters always valid, ownership alternates 0, 1, 0, 1.
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_4000;
        dtlb_req_valid_i = 1'b1;
        dtlb_vaddr_i     = 32'h0000_5000;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("fair_grant", {itlb_req_ready_o, dtlb_req_ready_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            applyStimulus(1);
            serveWalk(1'(i % 2), (i % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000, 32'h2000_0000 + 32'(i), 1);
        end
        itlb_req_valid_i = 1'b0;
        dtlb_req_valid_i = 1'b0;

        // Backpressure on both the PTW request and the dtlb response, with itlb kept waiting.
        applyStimulus(1);
        dtlb_req_valid_i = 1'b1;
        dtlb_vaddr_i     = 32'h0000_3000;
        #1;
        checkOutput("bp_dtlb_ready", dtlb_req_ready_o, 1'b1);
        applyStimulus(1);
        dtlb_req_valid_i = 1'b0;
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_6000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_req_valid", ptw_req_valid_o, 1'b1);
            checkOutput("bp_vaddr_stable", ptw_vaddr_o, 32'h0000_3000);
            checkOutput("bp_itlb_blocked", itlb_req_ready_o, 1'b0);
            applyStimulus(1);
        end
        ptw_req_ready_i = 1'b1;
        applyStimulus(1);
        ptw_req_ready_i  = 1'b0;
        ptw_resp_valid_i = 1'b1;
        ptw_pte_i        = 32'h2200_0003;
        applyStimulus(1);
        ptw_resp_valid_i = 1'b0;
        ptw_pte_i        = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_resp_valid", dtlb_resp_valid_o, 1'b1);
            checkOutput("bp_pte_stable", dtlb_pte_o, 32'h2200_0003);
            checkOutput("bp_itlb_blocked2", itlb_req_ready_o, 1'b0);
            applyStimulus(1);
        end
        dtlb_resp_ready_i = 1'b1;
        applyStimulus(1);
        dtlb_resp_ready_i = 1'b0;
        #1;
        checkOutput("bp_idle", busy_o, 1'b0);
        checkOutput("bp_itlb_granted", itlb_req_ready_o, 1'b1);

        // Reset during WAIT clears every output at once, and a fresh walk then completes.
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        #1;
        checkOutput("mid_vaddr", ptw_vaddr_o, 32'h0000_6000);
        ptw_req_ready_i = 1'b1;
        applyStimulus(1);
        ptw_req_ready_i = 1'b0;
        #1;
        checkOutput("mid_wait", ptw_resp_ready_o, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ctrl", {busy_o, ptw_resp_ready_o, ptw_req_valid_o, owner_o}, 4'b0);
        checkOutput("mid_rst_vaddr", ptw_vaddr_o, 32'h0);
        checkOutput("mid_rst_pte", {itlb_pte_o, dtlb_pte_o}, 64'h0);
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_7000;
        #1;
        checkOutput("post_rst_ready", itlb_req_ready_o, 1'b1);
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        serveWalk(1'b0, 32'h0000_7000, 32'h3300_0001, 2);

`ifdef PTW_ARB_MERGE_EN
        // A same-page dtlb request during WAIT shares the itlb walk.
        applyStimulus(1);
        itlb_req_valid_i = 1'b1;
        itlb_vaddr_i     = 32'h0000_1000;
        #1;
        checkOutput("merge_itlb_ready", itlb_req_ready_o, 1'b1);
        applyStimulus(1);
        itlb_req_valid_i = 1'b0;
        ptw_req_ready_i  = 1'b1;
        applyStimulus(1);
        ptw_req_ready_i  = 1'b0;
        dtlb_req_valid_i = 1'b1;
        dtlb_vaddr_i     = 32'h0000_1ABC;
        #1;
        checkOutput("merge_dtlb_ready", dtlb_req_ready_o, 1'b1);
        applyStimulus(1);
        dtlb_req_valid_i = 1'b0;
        #1;
        checkOutput("merge_ready_pulse", dtlb_req_ready_o, 1'b0);
        checkOutput("merge_single_req", ptw_req_valid_o, 1'b0);
        ptw_resp_valid_i = 1'b1;
        ptw_pte_i        = 32'h1100_000F;
        applyStimulus(1);
        ptw_resp_valid_i = 1'b0;
        #1;
        checkOutput("merge_both_valid", {itlb_resp_valid_o, dtlb_resp_valid_o}, 2'b11);
        checkOutput("merge_ptes", {itlb_pte_o, dtlb_pte_o}, {32'h1100_000F, 32'h1100_000F});
        itlb_resp_ready_i = 1'b1;
        applyStimulus(1);
        itlb_resp_ready_i = 1'b0;
        #1;
        checkOutput("merge_dtlb_left", {itlb_resp_valid_o, dtlb_resp_valid_o, busy_o}, 3'b011);
        dtlb_resp_ready_i = 1'b1;
        applyStimulus(1);
        dtlb_resp_ready_i = 1'b0;
        #1;
        checkOutput("merge_idle", busy_o, 1'b0);
`endif

        applyStimulus(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
